master_out_port: RTL
====================

Name: master_out_port

Overview:
- Master-side serialiser sitting directly upstream of the slave input port on the system bus.
- Takes a parallel transaction request (address, mode, burst length, write data) from the master core.
- Performs the valid/ready handshake with the slave, then shifts the 12-bit address on tx_addr and, for writes, each 8-bit data beat on tx_data, LSB-first, one bit per clk.

Parameters:
- ADDR_W, 12, address width in bits (shift length on tx_addr).
- DATA_W, 8, data beat width in bits (shift length on tx_data).
- BURST_W, 13, burst beat-count width; encodes 1..4096 beats.

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request pulse; sampled only in IDLE
- mode  input  1  1 = write, 0 = read; captured with start
- addr_in  input  ADDR_W  transaction start address; captured with start
- burst_len  input  BURST_W  number of beats; 0 is treated as 1; captured with start
- data_in  input  DATA_W  write beat from core FIFO (first-word-fall-through); must be valid while data_req=1
- slave_ready  input  1  slave can accept a transaction
- tx_addr  output  1  serial address line
- tx_data  output  1  serial write-data line
- master_valid  output  1  transaction in progress toward slave
- read_en  output  1  qualifies the transaction as a read
- write_en  output  1  qualifies the transaction as a write
- burst  output  BURST_W  captured beat count (0 already mapped to 1), stable while master_valid=1
- data_req  output  1  one-cycle pop strobe to core FIFO; data_in is loaded on the same edge
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle completion pulse

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Reset asserted mid-transfer aborts immediately; the next cycle is IDLE with all outputs 0.
- States: IDLE, WAIT_READY, SEND_ADDR, LOAD_DATA, SEND_DATA, DONE.
- IDLE:
  - On start=1, capture addr_in into the address shift register, and capture mode and burst (0 mapped to 1).
  - Go to WAIT_READY. Otherwise stay in IDLE.
- WAIT_READY:
  - master_valid=1; read_en=!mode, write_en=mode; burst driven.
  - On slave_ready=1, go to SEND_ADDR. There is no timeout.
- SEND_ADDR: ADDR_W cycles. Cycle k drives tx_addr=addr[k] (k=0 first). After bit ADDR_W-1: write goes to LOAD_DATA, read goes to DONE.
- LOAD_DATA:
  - One cycle with data_req=1; the data shift register loads data_in on this edge.
  - tx_data=0; go to SEND_DATA.
- SEND_DATA: DATA_W cycles, tx_data=data[k] LSB-first. After bit DATA_W-1, decrement the beat counter. If beats remain, go to LOAD_DATA (this doubles as a one-cycle inter-beat gap). Otherwise go to DONE.
- DONE:
  - done=1 for one cycle; master_valid, read_en and write_en drop to 0 here.
  - Go to IDLE.
- Line idle values: tx_addr and tx_data are 0 whenever not shifting a bit.
- Signal holds:
  - master_valid, read_en, write_en and burst hold constant from WAIT_READY through the last SEND_* bit.
  - slave_ready is ignored after leaving WAIT_READY.
- start while busy=1 is ignored; no queuing.
- Latency, start at cycle 0 with slave_ready=1:
  - Read: done at cycle 14.
  - Write: done at cycle 14 + 9*N (N beats). For N=1, done at cycle 23.
- Counters:
  - Bit counter is 4 bits and saturates at max(ADDR_W, DATA_W)-1 before reload.
  - Beat counter is BURST_W bits; 4096 beats must not wrap.

Decomposition:
- Shared package (bus_pkg): ADDR_W, DATA_W, BURST_W constants; state encoding for this FSM; MODE_READ/MODE_WRITE constants (shared with slave_in_port).
- One sub-module: piso_shift (parameter WIDTH; load, shift_en, par_in, ser_out), instantiated twice, once for address and once for data.

Test Plan:
- Read, addr_in=12'hA5C, burst_len=1, slave_ready=1 -> tx_addr bits 0,0,1,1,1,0,1,0,0,1,0,1 on cycles 2..13; read_en=1, write_en=0; data_req never asserts; done at cycle 14.
- Write, addr_in=12'h001, data_in=8'hC3, burst_len=1 -> data_req at cycle 14; tx_data 1,1,0,0,0,0,1,1 on cycles 15..22; done at cycle 23.
- Write burst_len=3 with FIFO bytes 8'h01, 8'h80, 8'hFF -> three data_req pulses at cycles 14, 23, 32; burst=3 throughout; done at cycle 41.
- slave_ready held 0 for 5 cycles after start -> remains in WAIT_READY with master_valid=1 and tx_addr=0; the first address bit appears the cycle after slave_ready rises.
- burst_len=0 write -> burst output reads 1; exactly one beat is sent. start pulsed again at cycle 10 -> ignored, only one done is produced.
- reset asserted at cycle 18 of a write -> at cycle 19 all outputs are 0 and the state is IDLE; a new start then completes normally.

Source files
------------

// File: rtl/master_out_port_pkg.sv
// Shared bus definitions for the master-side serialiser: widths, mode encoding
// and the transmit FSM state encoding.
package master_out_port_pkg;

    localparam int ADDR_W  = 12;
    localparam int DATA_W  = 8;
    localparam int BURST_W = 13;

    // Bit counter width covers max(ADDR_W, DATA_W) positions.
    localparam int CNT_W = 4;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_READY = 3'd1,
        ST_SEND_ADDR  = 3'd2,
        ST_LOAD_DATA  = 3'd3,
        ST_SEND_DATA  = 3'd4,
        ST_DONE       = 3'd5
    } mop_state_e;

    // A zero-length request still moves one beat.
    function automatic logic [BURST_W-1:0] map_burst(input logic [BURST_W-1:0] len);
        return (len == '0) ? BURST_W'(1) : len;
    endfunction

endpackage

// File: rtl/master_out_port_if.sv
// Core-request and slave-facing signals of the master output port, bundled
// with a master view (the port itself) and a slave view (core/slave side).
interface master_out_port_if;
    import master_out_port_pkg::*;

    logic               start;
    logic               mode;
    logic [ADDR_W-1:0]  addr_in;
    logic [BURST_W-1:0] burst_len;
    logic [DATA_W-1:0]  data_in;
    logic               slave_ready;

    logic               tx_addr;
    logic               tx_data;
    logic               master_valid;
    logic               read_en;
    logic               write_en;
    logic [BURST_W-1:0] burst;
    logic               data_req;
    logic               busy;
    logic               done;

    modport master (
        input  start, mode, addr_in, burst_len, data_in, slave_ready,
        output tx_addr, tx_data, master_valid, read_en, write_en, burst,
               data_req, busy, done
    );

    modport slave (
        output start, mode, addr_in, burst_len, data_in, slave_ready,
        input  tx_addr, tx_data, master_valid, read_en, write_en, burst,
               data_req, busy, done
    );

endinterface

// File: rtl/master_out_port_piso_shift.sv
// Parallel-in serial-out shift register, LSB first. Load wins over shift.
module piso_shift #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] par_in,
    output logic             ser_out
);

    logic [WIDTH-1:0] sr;

    always_ff @(posedge clk) begin
        if (reset) begin
            sr <= '0;
        end else if (load) begin
            sr <= par_in;
        end else if (shift_en) begin
            sr <= {1'b0, sr[WIDTH-1:1]};
        end
    end

    assign ser_out = sr[0];

endmodule

// File: rtl/master_out_port.sv
// Master-side bus serialiser: handshakes with the slave, then shifts the
// address and (for writes) each data beat out LSB-first, one bit per clk.
//
// state         | meaning
// --------------+--------------------------------------------------------
// ST_IDLE       | waiting for start; request fields captured on start
// ST_WAIT_READY | master_valid up, waiting for slave_ready (no timeout)
// ST_SEND_ADDR  | ADDR_W cycles of tx_addr, LSB first
// ST_LOAD_DATA  | one-cycle FIFO pop (data_req), also the inter-beat gap
// ST_SEND_DATA  | DATA_W cycles of tx_data, LSB first
// ST_DONE       | one-cycle done pulse, qualifiers already dropped
module master_out_port #(
    parameter int ADDR_W  = master_out_port_pkg::ADDR_W,
    parameter int DATA_W  = master_out_port_pkg::DATA_W,
    parameter int BURST_W = master_out_port_pkg::BURST_W
) (
    input  logic            clk,
    input  logic            reset,
    master_out_port_if.master bus
);
    import master_out_port_pkg::*;

    localparam int SHIFT_MAX = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;

    mop_state_e         state;
    logic               mode_q;
    logic [CNT_W-1:0]   bit_cnt;
    logic [BURST_W-1:0] beat_cnt;
    logic [BURST_W-1:0] burst_q;
    logic               valid_q;
    logic               rd_q;
    logic               wr_q;
    logic               req_q;
    logic               busy_q;
    logic               done_q;
    logic               addr_sh;
    logic               data_sh;

    logic               addr_ser;
    logic               data_ser;
    logic               addr_load;
    logic               data_load;
    logic               last_addr_bit;
    logic               last_data_bit;
    logic [CNT_W-1:0]   bit_cnt_inc;

    assign addr_load     = (state == ST_IDLE) && bus.start;
    assign data_load     = (state == ST_LOAD_DATA);
    assign last_addr_bit = (bit_cnt == CNT_W'(ADDR_W - 1));
    assign last_data_bit = (bit_cnt == CNT_W'(DATA_W - 1));
    assign bit_cnt_inc   = (bit_cnt == CNT_W'(SHIFT_MAX - 1)) ? bit_cnt
                                                              : bit_cnt + CNT_W'(1);

    piso_shift #(.WIDTH(ADDR_W)) u_addr_sr (
        .clk      (clk),
        .reset    (reset),
        .load     (addr_load),
        .shift_en (addr_sh),
        .par_in   (bus.addr_in),
        .ser_out  (addr_ser)
    );

    piso_shift #(.WIDTH(DATA_W)) u_data_sr (
        .clk      (clk),
        .reset    (reset),
        .load     (data_load),
        .shift_en (data_sh),
        .par_in   (bus.data_in),
        .ser_out  (data_ser)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            mode_q   <= MODE_READ;
            bit_cnt  <= '0;
            beat_cnt <= '0;
            burst_q  <= '0;
            valid_q  <= 1'b0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            req_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            addr_sh  <= 1'b0;
            data_sh  <= 1'b0;
        end else begin
            req_q  <= 1'b0;
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        mode_q   <= bus.mode;
                        burst_q  <= map_burst(bus.burst_len);
                        beat_cnt <= map_burst(bus.burst_len);
                        valid_q  <= 1'b1;
                        rd_q     <= (bus.mode == MODE_READ);
                        wr_q     <= (bus.mode == MODE_WRITE);
                        busy_q   <= 1'b1;
                        state    <= ST_WAIT_READY;
                    end
                end
                ST_WAIT_READY: begin
                    if (bus.slave_ready) begin
                        bit_cnt <= '0;
                        addr_sh <= 1'b1;
                        state   <= ST_SEND_ADDR;
                    end
                end
                ST_SEND_ADDR: begin
                    if (last_addr_bit) begin
                        bit_cnt <= '0;
                        addr_sh <= 1'b0;
                        if (mode_q == MODE_WRITE) begin
                            req_q <= 1'b1;
                            state <= ST_LOAD_DATA;
                        end else begin
                            done_q  <= 1'b1;
                            valid_q <= 1'b0;
                            rd_q    <= 1'b0;
                            wr_q    <= 1'b0;
                            burst_q <= '0;
                            state   <= ST_DONE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt_inc;
                    end
                end
                ST_LOAD_DATA: begin
                    bit_cnt <= '0;
                    data_sh <= 1'b1;
                    state   <= ST_SEND_DATA;
                end
                ST_SEND_DATA: begin
                    if (last_data_bit) begin
                        bit_cnt  <= '0;
                        data_sh  <= 1'b0;
                        beat_cnt <= beat_cnt - BURST_W'(1);
                        // beat_cnt still holds the pre-decrement count here
                        if (beat_cnt == BURST_W'(1)) begin
                            done_q  <= 1'b1;
                            valid_q <= 1'b0;
                            rd_q    <= 1'b0;
                            wr_q    <= 1'b0;
                            burst_q <= '0;
                            state   <= ST_DONE;
                        end else begin
                            req_q <= 1'b1;
                            state <= ST_LOAD_DATA;
                        end
                    end else begin
                        bit_cnt <= bit_cnt_inc;
                    end
                end
                ST_DONE: begin
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Shift flags are registered, so the lines are forced low between shifts.
    assign bus.tx_addr      = addr_sh & addr_ser;
    assign bus.tx_data      = data_sh & data_ser;
    assign bus.master_valid = valid_q;
    assign bus.read_en      = rd_q;
    assign bus.write_en     = wr_q;
    assign bus.burst        = burst_q;
    assign bus.data_req     = req_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;

endmodule
